// File: rtl/reg_wb_stage.sv
// reg_wb_stage: write-back staging FIFO placed in front of the dffe register array.
// Accepts write requests through a valid/ready handshake and drains them one per
// cycle onto registered active-low write-enable, address and data lines. It also
// forwards pending values so readers see writes that have not reached the array yet.
module reg_wb_stage #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_addr,
    input  logic [DW-1:0]              in_data,
    input  logic                       wb_stall,
    output logic                       wen_n,
    output logic [AW-1:0]              wr_addr,
    output logic [DW-1:0]              wr_data,
    input  logic [AW-1:0]              rd_addr,
    output logic                       fwd_hit,
    output logic [DW-1:0]              fwd_data,
    output logic [$clog2(DEPTH):0]     pending
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];

    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    logic          push;
    logic          pop;

    // Ready comes only from the registered count, so there is no path from
    // wb_stall or in_valid. It is held low while reset is asserted.
    assign in_ready = !clrn && (count_reg < CW'(DEPTH));
    // A request to register 0 completes the handshake but creates no entry.
    assign push     = in_valid && in_ready && (in_addr != '0);
    assign pop      = !wb_stall && (count_reg != '0);
    assign pending  = count_reg;

    // Occupancy changes by at most one per cycle. It stays the same on a
    // simultaneous push and pop.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Head/tail pointers and count. Reset discards every buffered entry.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + 1'b1;
            if (pop)  head_reg <= head_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // Entry storage. It needs no reset because count marks which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[tail_reg] <= in_addr;
            mem_data[tail_reg] <= in_data;
        end
    end

    // Registered outputs toward the array. Address and data hold when no write is issued.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            wen_n   <= 1'b1;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (pop) begin
            wen_n   <= 1'b0;
            wr_addr <= mem_addr[head_reg];
            wr_data <= mem_data[head_reg];
        end else begin
            wen_n   <= 1'b1;
        end
    end

    // Per-slot match. Slot gi is the entry gi positions after the head
    // (slot 0 is the oldest entry).
    logic [DEPTH-1:0] slot_hit;
    logic [PW-1:0]    slot_idx [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign slot_idx[gi] = head_reg + PW'(gi);
            assign slot_hit[gi] = (CW'(gi) < count_reg) &&
                                  (mem_addr[slot_idx[gi]] == rd_addr);
        end
    endgenerate

    // Forwarding lookup. The output register has the lowest priority, then the
    // slots from oldest to newest, so the newest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (!wen_n && (wr_addr == rd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = wr_data;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_hit[k]) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data[slot_idx[k]];
            end
        end
        if (rd_addr == '0) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end

endmodule
